// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALUOp encodings and stage control bundles for the pipelined control unit.
// The optional illegal-opcode trap in ctrl_pipe_unit is enabled with CTRL_ILLEGAL_TRAP_EN.
package ctrl_pkg;

    localparam int DEF_OPCODE_W = 6;
    localparam int DEF_ALUOP_W  = 3;
    localparam int DEF_REG_W    = 5;

    localparam logic [DEF_OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [DEF_OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [DEF_OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [DEF_OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [DEF_OPCODE_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [DEF_OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [DEF_OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [DEF_OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [DEF_OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [DEF_OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [DEF_ALUOP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [DEF_ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [DEF_ALUOP_W-1:0] ALU_FUNCT = 3'b010;
    localparam logic [DEF_ALUOP_W-1:0] ALU_AND   = 3'b011;
    localparam logic [DEF_ALUOP_W-1:0] ALU_OR    = 3'b100;
    localparam logic [DEF_ALUOP_W-1:0] ALU_SLT   = 3'b101;

    typedef struct packed {
        logic                   reg_dst;
        logic                   alu_src;
        logic                   branch;
        logic                   branch_ne;
        logic                   jump;
        logic [DEF_ALUOP_W-1:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    function automatic logic opcode_defined(input logic [DEF_OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: opcode_defined = 1'b1;
            default:                            opcode_defined = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode-to-control-bundle decoder; undefined opcodes decode to a NOP bundle.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [DEF_OPCODE_W-1:0] opcode,
    output ctrl_bundle_t            ctrl
);

    always_comb begin
        ctrl = CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                ctrl.ex.reg_dst   = 1'b1;
                ctrl.ex.alu_op    = ALU_FUNCT;
                ctrl.wb.reg_write = 1'b1;
            end
            OP_ADDI: begin
                ctrl.ex.alu_src   = 1'b1;
                ctrl.ex.alu_op    = ALU_ADD;
                ctrl.wb.reg_write = 1'b1;
            end
            OP_ANDI: begin
                ctrl.ex.alu_src   = 1'b1;
                ctrl.ex.alu_op    = ALU_AND;
                ctrl.wb.reg_write = 1'b1;
            end
            OP_ORI: begin
                ctrl.ex.alu_src   = 1'b1;
                ctrl.ex.alu_op    = ALU_OR;
                ctrl.wb.reg_write = 1'b1;
            end
            OP_SLTI: begin
                ctrl.ex.alu_src   = 1'b1;
                ctrl.ex.alu_op    = ALU_SLT;
                ctrl.wb.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl.ex.alu_src    = 1'b1;
                ctrl.ex.alu_op     = ALU_ADD;
                ctrl.mem.mem_read  = 1'b1;
                ctrl.wb.mem_to_reg = 1'b1;
                ctrl.wb.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl.ex.alu_src    = 1'b1;
                ctrl.ex.alu_op     = ALU_ADD;
                ctrl.mem.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.ex.branch = 1'b1;
                ctrl.ex.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                ctrl.ex.branch_ne = 1'b1;
                ctrl.ex.alu_op    = ALU_SUB;
            end
            OP_J: begin
                ctrl.ex.jump = 1'b1;
            end
            default: ctrl = CTRL_BUBBLE;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined main control: decodes ID, carries controls through ID/EX, EX/MEM, MEM/WB and detects load-use hazards.
// Define CTRL_ILLEGAL_TRAP_EN to add the illegal_sticky output that flags undefined opcodes.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = DEF_OPCODE_W,
    parameter int ALUOP_W  = DEF_ALUOP_W,
    parameter int REG_W    = DEF_REG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                stall_in,
    input  logic                flush_in,
    output logic                hazard_out,
    output logic                ex_reg_dst,
    output logic                ex_alu_src,
    output logic                ex_branch,
    output logic                ex_branch_ne,
    output logic                ex_jump,
    output logic [ALUOP_W-1:0]  ex_alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_sticky
`endif
);

    ctrl_bundle_t    id_ctrl;
    ctrl_bundle_t    id_ex;
    ctrl_bundle_t    id_ex_next;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] ex_rt_next;
    mem_ctrl_t       ex_mem_mem;
    wb_ctrl_t        ex_mem_wb;
    wb_ctrl_t        mem_wb_wb;

    ctrl_decode u_decode (
        .opcode (id_opcode),
        .ctrl   (id_ctrl)
    );

    always_comb begin
        hazard_out = id_ex.mem.mem_read & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (ex_rt == id_rt)) & id_valid;
    end

    // Flush, hazard, stall and an empty ID slot all collapse to the same bubble, so one bubble per cycle at most.
    always_comb begin
        id_ex_next = id_ctrl;
        ex_rt_next = id_rt;
        if (flush_in || hazard_out || stall_in || !id_valid) begin
            id_ex_next = CTRL_BUBBLE;
            ex_rt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex      <= CTRL_BUBBLE;
            ex_rt      <= '0;
            ex_mem_mem <= '0;
            ex_mem_wb  <= '0;
            mem_wb_wb  <= '0;
        end else begin
            id_ex      <= id_ex_next;
            ex_rt      <= ex_rt_next;
            ex_mem_mem <= id_ex.mem;
            ex_mem_wb  <= id_ex.wb;
            mem_wb_wb  <= ex_mem_wb;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_sticky <= 1'b0;
        end else if (id_valid && !flush_in && !opcode_defined(id_opcode)) begin
            illegal_sticky <= 1'b1;
        end
    end
`endif

    always_comb begin
        ex_reg_dst    = id_ex.ex.reg_dst;
        ex_alu_src    = id_ex.ex.alu_src;
        ex_branch     = id_ex.ex.branch;
        ex_branch_ne  = id_ex.ex.branch_ne;
        ex_jump       = id_ex.ex.jump;
        ex_alu_op     = id_ex.ex.alu_op;
        mem_read      = ex_mem_mem.mem_read;
        mem_write     = ex_mem_mem.mem_write;
        wb_reg_write  = mem_wb_wb.reg_write;
        wb_mem_to_reg = mem_wb_wb.mem_to_reg;
    end

endmodule
